// File: rtl/store_buffer_v2.sv
// ---------------------------------------------------------------------------
// store_buffer_v2
//   Circular store buffer between the memory execution unit and the data
//   cache write port. Entries [head,cmt) are committed (non-speculative) and
//   drain in order to the cache; entries [cmt,tail) are speculative and are
//   discarded by a flush. Loads get byte-granular forwarding from every
//   valid entry, with the youngest matching store winning each byte.
//
// Optional build macro: SB_PERF_CNT_EN adds two saturating perf counters
//   (perf_full_stall_o, perf_fwd_hit_o).
//
// Ports:
//   cpu_clk_i / cpu_rst_i        clock, asynchronous active-high reset
//   flush_i                      discard all speculative entries
//   enqueue_*                    store write from the execution unit
//   complete_o/complete_vld_o    zero-cycle completion of accepted store
//   commit_cnt_i                 number of oldest speculative stores retiring
//   conflict_*                   load forwarding lookup (combinational)
//   store_* / store_ready_i      in-order drain handshake to the cache
//   no_nonspec_o / empty_o       occupancy status
// ---------------------------------------------------------------------------
module store_buffer_v2 #(
  parameter int PHYS    = 32,
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int ROBW    = 5,
  parameter int CWIDTH  = 2,
  localparam int BYTES  = XLEN / 8,
  localparam int AW     = PHYS - $clog2(BYTES),
  localparam int IW     = $clog2(ENTRIES),
  localparam int PW     = IW + 1,
  localparam int CW     = $clog2(CWIDTH + 1)
) (
  input  logic             cpu_clk_i,
  input  logic             cpu_rst_i,
  input  logic             flush_i,
  input  logic [AW-1:0]    enqueue_address_i,
  input  logic [XLEN-1:0]  enqueue_data_i,
  input  logic [BYTES-1:0] enqueue_bm_i,
  input  logic             enqueue_io_i,
  input  logic             enqueue_en_i,
  input  logic [ROBW-1:0]  enqueue_rob_i,
  output logic             enqueue_full_o,
  output logic [ROBW-1:0]  complete_o,
  output logic             complete_vld_o,
  input  logic [CW-1:0]    commit_cnt_i,
  input  logic [AW-1:0]    conflict_address_i,
  input  logic [BYTES-1:0] conflict_bm_i,
  output logic [XLEN-1:0]  conflict_data_o,
  output logic [BYTES-1:0] conflict_bm_o,
  output logic             conflict_res_valid_o,
  output logic             conflict_resolvable_o,
  output logic [AW-1:0]    store_address_o,
  output logic [XLEN-1:0]  store_data_o,
  output logic [BYTES-1:0] store_bm_o,
  output logic             store_io_o,
  output logic             store_valid_o,
  input  logic             store_ready_i,
  output logic             no_nonspec_o,
`ifdef SB_PERF_CNT_EN
  output logic [31:0]      perf_full_stall_o,
  output logic [31:0]      perf_fwd_hit_o,
`endif
  output logic             empty_o
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cmt_q, cmt_d;
  logic [PW-1:0] tail_q, tail_d;

  // Entry storage; validity is implied by the pointers, so no reset needed.
  logic [AW-1:0]    addr_q [ENTRIES];
  logic [XLEN-1:0]  data_q [ENTRIES];
  logic [BYTES-1:0] bm_q   [ENTRIES];
  logic             io_q   [ENTRIES];

  logic [PW-1:0] occ;
  logic [PW-1:0] spec_cnt;
  logic [PW-1:0] cnt_ext;
  logic [PW-1:0] commit_amt;
  logic          full;
  logic          enq_fire;
  logic          drain_fire;

  assign occ        = tail_q - head_q;
  assign spec_cnt   = tail_q - cmt_q;
  assign cnt_ext    = PW'(commit_cnt_i);
  // Commit only looks at entries that existed before this cycle.
  assign commit_amt = (cnt_ext > spec_cnt) ? spec_cnt : cnt_ext;
  assign full       = (occ == PW'(ENTRIES));
  assign enq_fire   = enqueue_en_i & ~full & ~flush_i;
  assign drain_fire = store_valid_o & store_ready_i;

  always_comb begin
    head_d = head_q + PW'(drain_fire);
    cmt_d  = cmt_q + commit_amt;
    tail_d = tail_q;
    if (flush_i) begin
      // Commits in the flush cycle survive: tail snaps to the new cmt.
      tail_d = cmt_d;
    end else if (enq_fire) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (enq_fire) begin
      addr_q[tail_q[IW-1:0]] <= enqueue_address_i;
      data_q[tail_q[IW-1:0]] <= enqueue_data_i;
      bm_q[tail_q[IW-1:0]]   <= enqueue_bm_i;
      io_q[tail_q[IW-1:0]]   <= enqueue_io_i;
    end
  end

  assign enqueue_full_o = full;
  assign complete_vld_o = enq_fire;
  assign complete_o     = enqueue_rob_i;

  // Drain port: head entry, valid only once it is committed.
  assign store_valid_o   = (cmt_q != head_q);
  assign store_address_o = addr_q[head_q[IW-1:0]];
  assign store_data_o    = data_q[head_q[IW-1:0]];
  assign store_bm_o      = bm_q[head_q[IW-1:0]];
  assign store_io_o      = io_q[head_q[IW-1:0]];

  assign no_nonspec_o = (cmt_q == head_q);
  assign empty_o      = (tail_q == head_q);

  // Forwarding: walk entries oldest to youngest so later (younger) matches
  // overwrite earlier ones byte by byte.
  logic [XLEN-1:0]  fwd_data;
  logic [BYTES-1:0] fwd_bm;
  logic [BYTES-1:0] ovl;
  logic [IW-1:0]    idx;
  logic             any_hit;
  logic             any_io;

  always_comb begin
    fwd_data = '0;
    fwd_bm   = '0;
    ovl      = '0;
    idx      = '0;
    any_hit  = 1'b0;
    any_io   = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      idx = head_q[IW-1:0] + IW'(k);
      ovl = '0;
      if ((PW'(k) < occ) && (addr_q[idx] == conflict_address_i)) begin
        ovl = bm_q[idx] & conflict_bm_i;
      end
      if (|ovl) begin
        any_hit = 1'b1;
        any_io  = any_io | io_q[idx];
      end
      for (int b = 0; b < BYTES; b++) begin
        if (ovl[b]) begin
          fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
          fwd_bm[b]          = 1'b1;
        end
      end
    end
  end

  assign conflict_data_o       = fwd_data;
  assign conflict_bm_o         = fwd_bm;
  assign conflict_res_valid_o  = any_hit;
  assign conflict_resolvable_o = (fwd_bm == conflict_bm_i) & ~any_io;

`ifdef SB_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_hit_q, perf_hit_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_hit_d   = perf_hit_q;
    if (enqueue_en_i && full && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (conflict_resolvable_o && conflict_res_valid_o && (perf_hit_q != '1)) begin
      perf_hit_d = perf_hit_q + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      perf_stall_q <= '0;
      perf_hit_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_hit_q   <= perf_hit_d;
    end
  end

  assign perf_full_stall_o = perf_stall_q;
  assign perf_fwd_hit_o    = perf_hit_q;
`endif

endmodule

// File: tb/tb_store_buffer_v2.sv
// ---------------------------------------------------------------------------
// tb_store_buffer_v2
//   Self-checking bench for store_buffer_v2 (default parameters). A queue
//   model holds the buffered stores in age order plus a count of committed
//   entries; every cycle all outputs are compared with what the model says.
// ---------------------------------------------------------------------------
module tb_store_buffer_v2;
  localparam int ENTRIES = 16;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  bm;
    logic        io;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [29:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_bm;
  logic        enq_io;
  logic        enq_en;
  logic [4:0]  enq_rob;
  logic        enq_full;
  logic [4:0]  cmpl;
  logic        cmpl_vld;
  logic [1:0]  cmt_cnt;
  logic [29:0] ld_addr;
  logic [3:0]  ld_bm;
  logic [31:0] cf_data;
  logic [3:0]  cf_bm;
  logic        cf_hit;
  logic        cf_res;
  logic [29:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_bm;
  logic        st_io;
  logic        st_vld;
  logic        st_rdy;
  logic        no_nonspec;
  logic        empty;
`ifdef SB_PERF_CNT_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_hit;
`endif

  store_buffer_v2 dut (
    .cpu_clk_i            (clk),
    .cpu_rst_i            (rst),
    .flush_i              (flush),
    .enqueue_address_i    (enq_addr),
    .enqueue_data_i       (enq_data),
    .enqueue_bm_i         (enq_bm),
    .enqueue_io_i         (enq_io),
    .enqueue_en_i         (enq_en),
    .enqueue_rob_i        (enq_rob),
    .enqueue_full_o       (enq_full),
    .complete_o           (cmpl),
    .complete_vld_o       (cmpl_vld),
    .commit_cnt_i         (cmt_cnt),
    .conflict_address_i   (ld_addr),
    .conflict_bm_i        (ld_bm),
    .conflict_data_o      (cf_data),
    .conflict_bm_o        (cf_bm),
    .conflict_res_valid_o (cf_hit),
    .conflict_resolvable_o(cf_res),
    .store_address_o      (st_addr),
    .store_data_o         (st_data),
    .store_bm_o           (st_bm),
    .store_io_o           (st_io),
    .store_valid_o        (st_vld),
    .store_ready_i        (st_rdy),
    .no_nonspec_o         (no_nonspec),
`ifdef SB_PERF_CNT_EN
    .perf_full_stall_o    (perf_stall),
    .perf_fwd_hit_o       (perf_hit),
`endif
    .empty_o              (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  ent_t q[$];
  int   ncmt     = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Negedge: default all inputs; caller then overrides what it needs.
  task automatic begin_cycle();
    @(negedge clk);
    flush    = 1'b0;
    enq_en   = 1'b0;
    enq_addr = '0;
    enq_data = '0;
    enq_bm   = '0;
    enq_io   = 1'b0;
    enq_rob  = 5'($urandom);
    cmt_cnt  = '0;
    st_rdy   = 1'b0;
    ld_addr  = 30'h3FFF_FFFF;
    ld_bm    = '0;
  endtask

  // Settle, then compare every output against the queue model.
  task automatic eval();
    logic [31:0] e_data;
    logic [3:0]  e_bm;
    logic        e_hit;
    logic        e_io;
    logic        e_full;
    logic        e_fire;
    #1;
    e_data = '0;
    e_bm   = '0;
    e_hit  = 1'b0;
    e_io   = 1'b0;
    // Youngest store first: a byte is taken from the first match found.
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr == ld_addr && (q[i].bm & ld_bm) != 4'h0) begin
        e_hit = 1'b1;
        if (q[i].io) e_io = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (ld_bm[b] && q[i].bm[b] && !e_bm[b]) begin
            e_bm[b] = 1'b1;
            e_data[8*b +: 8] = q[i].data[8*b +: 8];
          end
        end
      end
    end
    e_full = (q.size() == ENTRIES);
    e_fire = enq_en && !e_full && !flush;
    chk("full", enq_full, e_full);
    chk("cmpl_vld", cmpl_vld, e_fire);
    if (e_fire) chk("cmpl_rob", cmpl, enq_rob);
    chk("st_vld", st_vld, ncmt > 0);
    if (ncmt > 0) begin
      chk("st_addr", st_addr, q[0].addr);
      chk("st_data", st_data, q[0].data);
      chk("st_bm", st_bm, q[0].bm);
      chk("st_io", st_io, q[0].io);
    end
    chk("no_nonspec", no_nonspec, ncmt == 0);
    chk("empty", empty, q.size() == 0);
    chk("cf_bm", cf_bm, e_bm);
    chk("cf_data", cf_data, e_data);
    chk("cf_hit", cf_hit, e_hit);
    chk("cf_res", cf_res, (e_bm == ld_bm) && !e_io);
  endtask

  // Clock edge, then advance the model with the inputs that were applied.
  task automatic tick();
    int   spec;
    int   commit;
    bit   full;
    bit   drain;
    bit   fire;
    ent_t e;
    spec   = q.size() - ncmt;
    assert (int'(cmt_cnt) <= spec) else $error("commit count exceeds speculative entries");
    commit = (int'(cmt_cnt) > spec) ? spec : int'(cmt_cnt);
    full   = (q.size() == ENTRIES);
    drain  = (ncmt > 0) && st_rdy;
    fire   = enq_en && !full && !flush;
    e.addr = enq_addr;
    e.data = enq_data;
    e.bm   = enq_bm;
    e.io   = enq_io;
    @(posedge clk);
    if (drain) begin
      void'(q.pop_front());
      ncmt--;
    end
    ncmt += commit;
    if (flush) while (q.size() > ncmt) void'(q.pop_back());
    if (fire) q.push_back(e);
    cyc++;
    $display("cyc %0d enq=%0d addr=%0h flush=%0d commit=%0d drain=%0d occ=%0d cmt=%0d",
             cyc, fire, e.addr, flush, commit, drain, q.size(), ncmt);
  endtask

  task automatic enq(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic io);
    begin_cycle();
    enq_en = 1'b1; enq_addr = a; enq_data = d; enq_bm = m; enq_io = io;
    eval();
    tick();
  endtask

  task automatic do_flush();
    begin_cycle();
    flush = 1'b1;
    eval();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; enq_en = 1'b0; enq_addr = '0; enq_data = '0; enq_bm = '0;
    enq_io = 1'b0; enq_rob = '0; cmt_cnt = '0; st_rdy = 1'b0;
    ld_addr = '0; ld_bm = '0;
    #2;
    chk("rst_full", enq_full, 1'b0);
    chk("rst_st_vld", st_vld, 1'b0);
    chk("rst_cmpl_vld", cmpl_vld, 1'b0);
    chk("rst_cf_hit", cf_hit, 1'b0);
    chk("rst_no_nonspec", no_nonspec, 1'b1);
    chk("rst_empty", empty, 1'b1);
    #10 rst = 1'b0;

    // Fill all 16 entries without committing.
    for (int i = 0; i < 16; i++) enq(30'h10 + 30'(i), $urandom, 4'hF, 1'b0);
    begin_cycle();
    enq_en = 1'b1; enq_addr = 30'h20; enq_bm = 4'hF;
    eval();
    chk("full_after_16", enq_full, 1'b1);
    chk("reject_17th", cmpl_vld, 1'b0);
    chk("spec_not_drained", st_vld, 1'b0);
    tick();

    // Commit two, drain them in order.
    begin_cycle(); cmt_cnt = 2'd2; st_rdy = 1'b1; eval(); tick();
    begin_cycle(); st_rdy = 1'b1; eval();
    chk("drain0_addr", st_addr, 30'h10); tick();
    begin_cycle(); st_rdy = 1'b1; eval();
    chk("drain1_addr", st_addr, 30'h11); tick();
    begin_cycle(); eval();
    chk("no_nonspec_after", no_nonspec, 1'b1); tick();
    do_flush();

    // Byte merge from two overlapping stores.
    enq(30'h40, 32'h0000_AABB, 4'b0011, 1'b0);
    enq(30'h40, 32'h00CC_DD00, 4'b0110, 1'b0);
    begin_cycle(); ld_addr = 30'h40; ld_bm = 4'b0111; eval();
    chk("merge_data", cf_data, 32'h00CC_DDBB);
    chk("merge_bm", cf_bm, 4'b0111);
    chk("merge_res", cf_res, 1'b1);
    tick();
    begin_cycle(); ld_addr = 30'h40; ld_bm = 4'b1111; eval();
    chk("partial_bm", cf_bm, 4'b0111);
    chk("partial_hit", cf_hit, 1'b1);
    chk("partial_res", cf_res, 1'b0);
    tick();
    enq(30'h40, 32'h0000_0011, 4'b1000, 1'b1);
    begin_cycle(); ld_addr = 30'h40; ld_bm = 4'b1001; eval();
    chk("io_res", cf_res, 1'b0);
    tick();
    do_flush();

    // Flush together with commit and a dropped enqueue.
    enq(30'h50, 32'h5050_5050, 4'hF, 1'b0);
    enq(30'h51, 32'h5151_5151, 4'hF, 1'b0);
    enq(30'h52, 32'h5252_5252, 4'hF, 1'b0);
    begin_cycle(); cmt_cnt = 2'd1; eval(); tick();
    begin_cycle(); flush = 1'b1; cmt_cnt = 2'd1; enq_en = 1'b1; enq_addr = 30'h53;
    enq_bm = 4'hF; eval();
    chk("flush_drop", cmpl_vld, 1'b0);
    tick();
    begin_cycle(); eval();
    chk("flush_kept_vld", st_vld, 1'b1);
    chk("flush_kept_head", st_addr, 30'h50);
    tick();
    for (int i = 0; i < 2; i++) begin
      begin_cycle(); st_rdy = 1'b1; eval(); tick();
    end
    begin_cycle(); eval();
    chk("flush_tail_eq_cmt", empty, 1'b1);
    tick();

    // Back-pressure: committed head held for 5 cycles.
    enq(30'h60, 32'hDEAD_BEEF, 4'hF, 1'b1);
    begin_cycle(); cmt_cnt = 2'd1; eval(); tick();
    for (int i = 0; i < 5; i++) begin
      begin_cycle(); eval();
      chk("hold_addr", st_addr, 30'h60);
      chk("hold_data", st_data, 32'hDEAD_BEEF);
      tick();
    end
    begin_cycle(); st_rdy = 1'b1; eval(); tick();

    // 40 enqueue/drain pairs across the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      begin_cycle();
      enq_en = 1'b1; enq_addr = 30'h100 + 30'(i); enq_data = $urandom; enq_bm = 4'hF;
      cmt_cnt = (q.size() > ncmt) ? 2'd1 : 2'd0;
      st_rdy = 1'b1;
      eval();
      tick();
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int spec;
      int mx;
      begin_cycle();
      spec     = q.size() - ncmt;
      mx       = (spec < 2) ? spec : 2;
      enq_en   = ($urandom_range(0, 1) == 1);
      enq_addr = 30'h40 + 30'($urandom_range(0, 3));
      enq_data = $urandom;
      enq_bm   = 4'($urandom);
      enq_io   = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      cmt_cnt  = 2'($urandom_range(0, mx));
      st_rdy   = ($urandom_range(0, 3) != 0);
      ld_addr  = 30'h40 + 30'($urandom_range(0, 3));
      ld_bm    = 4'($urandom);
      eval();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
